// File: rtl/prefetch_ctrl.sv
// Prefetch buffer sequencing controller: credit-limited sequential fetch,
// in-order response forwarding, and redirect flush with stale-response drain.
//
// state | meaning
// FETCH | issuing requests and forwarding responses into the buffer
// DRAIN | discarding responses to requests issued before a redirect
module prefetch_ctrl #(
   parameter int          DEPTH           = 8,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        buf_write_enable,
   output logic [31:0] buf_write_data,
   output logic [31:0] buf_write_pc,
   output logic        buf_flush,
   input  logic [3:0]  buf_count,
   output logic        draining,
   output logic        stale_drop
);

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] req_pc, req_pc_nxt;
   logic [31:0] resp_pc, resp_pc_nxt;
   logic [2:0]  outstanding, outstanding_nxt;
   logic [2:0]  drop_cnt, drop_cnt_nxt;
   logic [2:0]  n_stale;
   logic [4:0]  credit_sum;
   logic        issue_ok;
   logic        fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         req_pc      <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= 3'd0;
         drop_cnt    <= 3'd0;
      end else begin
         state       <= state_nxt;
         req_pc      <= req_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      req_pc_nxt       = req_pc;
      resp_pc_nxt      = resp_pc;
      outstanding_nxt  = outstanding;
      drop_cnt_nxt     = drop_cnt;
      buf_write_enable = 1'b0;
      buf_write_data   = mem_resp_data;
      buf_write_pc     = resp_pc;
      buf_flush        = 1'b0;
      stale_drop       = 1'b0;
      draining         = (state == DRAIN);
      mem_req_addr     = req_pc;

      // outstanding already counts in-flight entries that buf_count has not seen yet
      credit_sum = {1'b0, buf_count} + {2'b00, outstanding};
      issue_ok   = (state == FETCH) && fetch_en && !redirect_valid &&
                   (outstanding < 3'(MAX_OUTSTANDING)) && (credit_sum < 5'(DEPTH));
      mem_req_valid = issue_ok;
      fire          = issue_ok && mem_req_ready;

      n_stale = (mem_resp_valid && (outstanding != 3'd0)) ? outstanding - 3'd1 : outstanding;

      if (redirect_valid) begin
         buf_flush       = 1'b1;
         stale_drop      = mem_resp_valid;
         req_pc_nxt      = {redirect_pc[31:2], 2'b00};
         resp_pc_nxt     = {redirect_pc[31:2], 2'b00};
         outstanding_nxt = n_stale;
         drop_cnt_nxt    = n_stale;
         state_nxt       = (n_stale != 3'd0) ? DRAIN : FETCH;
      end else if (state == FETCH) begin
         if (fire) begin
            req_pc_nxt = req_pc + 32'd4;
         end
         if (mem_resp_valid) begin
            buf_write_enable = 1'b1;
            resp_pc_nxt      = resp_pc + 32'd4;
         end
         outstanding_nxt = outstanding + 3'(fire) - 3'(mem_resp_valid);
      end else begin
         if (mem_resp_valid) begin
            stale_drop      = 1'b1;
            outstanding_nxt = outstanding - 3'd1;
            drop_cnt_nxt    = drop_cnt - 3'd1;
            if (drop_cnt <= 3'd1) begin
               state_nxt = FETCH;
            end
         end else if (drop_cnt == 3'd0) begin
            state_nxt = FETCH;
         end
      end

      if (rst) begin
         mem_req_valid    = 1'b0;
         mem_req_addr     = 32'd0;
         buf_write_enable = 1'b0;
         buf_write_data   = 32'd0;
         buf_write_pc     = 32'd0;
         buf_flush        = 1'b0;
         draining         = 1'b0;
         stale_drop       = 1'b0;
         fire             = 1'b0;
      end
   end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Directed bench for prefetch_ctrl with a latency-configurable memory model,
// a registered buffer-occupancy model and an expected-write-PC scoreboard.
module tb_prefetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b1;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'd0;
   logic        buf_write_enable;
   logic [31:0] buf_write_data;
   logic [31:0] buf_write_pc;
   logic        buf_flush;
   logic [3:0]  buf_count = 4'd0;
   logic        draining;
   logic        stale_drop;

   prefetch_ctrl dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .buf_write_enable(buf_write_enable),
      .buf_write_data(buf_write_data), .buf_write_pc(buf_write_pc),
      .buf_flush(buf_flush), .buf_count(buf_count),
      .draining(draining), .stale_drop(stale_drop)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] req_log[$];
   logic [31:0] wr_log[$];
   int          cyc, lat, bc, tb_out, max_out, n_stale_seen;
   logic        buf_rd, stress;
   logic [31:0] exp_wr_pc;
   logic        o_valid, o_we, o_flush, o_drain, o_stale;
   logic [31:0] o_addr, o_pc, o_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: observe at negedge, update models at posedge, drive at posedge+1.
   task automatic tick();
      @(negedge clk);
      o_valid = mem_req_valid;  o_addr  = mem_req_addr;
      o_we    = buf_write_enable; o_pc  = buf_write_pc; o_data = buf_write_data;
      o_flush = buf_flush;      o_drain = draining;     o_stale = stale_drop;
      if (!rst) begin
         if (mem_req_valid && mem_req_ready) begin
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + lat);
            req_log.push_back(mem_req_addr);
            tb_out++;
         end
         if (mem_resp_valid) tb_out--;
         if (tb_out > max_out) max_out = tb_out;
         if (buf_write_enable) begin
            chk("wr_pc", buf_write_pc, exp_wr_pc);
            chk("wr_data", buf_write_data, ~exp_wr_pc);
            wr_log.push_back(buf_write_pc);
            exp_wr_pc = exp_wr_pc + 32'd4;
         end
         if (stale_drop) n_stale_seen++;
         if (redirect_valid) exp_wr_pc = {redirect_pc[31:2], 2'b00};
      end
      @(posedge clk);
      if (o_flush) bc = 0;
      else bc = bc + (o_we ? 1 : 0) - ((buf_rd && bc > 0) ? 1 : 0);
      #1;
      cyc++;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'd0;
      if (rst) begin
         mem_resp_valid = stress;
      end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = ~q_addr[0];
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      buf_count = 4'(bc);
   endtask

   task automatic do_reset(input logic stress_in);
      rst = 1'b1;
      stress = stress_in;
      if (stress_in) begin
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0000_0100;
         mem_resp_valid = 1'b1;
         fetch_en       = 1'b1;
      end
      q_addr.delete(); q_due.delete();
      bc = 0; buf_count = 4'd0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_valid", {31'd0, o_valid}, 32'd0);
         chk("rst_addr", o_addr, 32'd0);
         chk("rst_we_flush", {29'd0, o_we, o_flush, o_stale}, 32'd0);
         chk("rst_drain", {31'd0, o_drain}, 32'd0);
         chk("rst_pc_data", o_pc | o_data, 32'd0);
      end
      rst = 1'b0;
      stress = 1'b0;
      redirect_valid = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'd0;
      fetch_en = 1'b0;
      buf_rd = 1'b0;
      mem_req_ready = 1'b1;
      q_addr.delete(); q_due.delete(); req_log.delete(); wr_log.delete();
      cyc = 0; tb_out = 0; max_out = 0; n_stale_seen = 0; bc = 0;
      exp_wr_pc = 32'd0;
   endtask

   initial begin
      int  drain_cyc;
      logic found;
      lat = 1; buf_rd = 1'b0; stress = 1'b0;

      // fill the buffer with L=1, no reads
      do_reset(1'b0);
      fetch_en = 1'b1;
      repeat (30) tick();
      chk("t1_nreq", 32'(req_log.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk("t1_req_addr", (i < req_log.size()) ? req_log[i] : 32'hdead_beef, 32'(4 * i));
      chk("t1_nwr", 32'(wr_log.size()), 32'd8);
      chk("t1_bc", 32'(bc), 32'd8);
      repeat (3) begin
         tick();
         chk("t1_full_novalid", {31'd0, o_valid}, 32'd0);
      end

      // L=5 with continuous reads
      do_reset(1'b0);
      lat = 5; buf_rd = 1'b1; fetch_en = 1'b1;
      repeat (40) tick();
      chk("t2_max_out", 32'(max_out), 32'd2);
      chk("t2_nwr_ge10", {31'd0, wr_log.size() >= 10}, 32'd1);

      // redirect with 2 outstanding, no response that cycle
      do_reset(1'b0);
      lat = 5; fetch_en = 1'b1;
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
      tick();
      chk("t3_flush", {31'd0, o_flush}, 32'd1);
      chk("t3_valid_redir", {31'd0, o_valid}, 32'd0);
      chk("t3_stale_redir", {31'd0, o_stale}, 32'd0);
      redirect_valid = 1'b0;
      drain_cyc = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (o_drain) drain_cyc++;
         if (o_valid) found = 1'b1;
      end
      chk("t3_req_seen", {31'd0, found}, 32'd1);
      chk("t3_drain_cycles", 32'(drain_cyc), 32'd4);
      chk("t3_stale_cnt", 32'(n_stale_seen), 32'd2);
      chk("t3_no_stale_wr", 32'(wr_log.size()), 32'd0);
      chk("t3_new_addr", o_addr, 32'h0000_1000);
      repeat (8) tick();
      chk("t3_first_wr_pc", (wr_log.size() > 0) ? wr_log[0] : 32'hdead_beef, 32'h0000_1000);

      // redirect coinciding with a response, outstanding=1
      do_reset(1'b0);
      lat = 3; fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; fetch_en = 1'b1;
      tick();
      chk("t4_stale", {31'd0, o_stale}, 32'd1);
      chk("t4_no_we", {31'd0, o_we}, 32'd0);
      chk("t4_flush", {31'd0, o_flush}, 32'd1);
      redirect_valid = 1'b0;
      tick();
      chk("t4_no_drain", {31'd0, o_drain}, 32'd0);
      chk("t4_valid", {31'd0, o_valid}, 32'd1);
      chk("t4_addr", o_addr, 32'h0000_0200);

      // stall and address wrap
      do_reset(1'b0);
      lat = 1; fetch_en = 1'b1; mem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      repeat (3) begin
         tick();
         chk("t5_stall_valid", {31'd0, o_valid}, 32'd1);
         chk("t5_stall_addr", o_addr, 32'hFFFF_FFF8);
      end
      mem_req_ready = 1'b1;
      repeat (3) tick();
      chk("t5_wrap0", (req_log.size() > 0) ? req_log[0] : 32'hdead_beef, 32'hFFFF_FFF8);
      chk("t5_wrap1", (req_log.size() > 1) ? req_log[1] : 32'hdead_beef, 32'hFFFF_FFFC);
      chk("t5_wrap2", (req_log.size() > 2) ? req_log[2] : 32'hdead_beef, 32'h0000_0000);

      // reset mid-operation with 2 outstanding
      do_reset(1'b0);
      lat = 5; fetch_en = 1'b1;
      tick(); tick();
      do_reset(1'b1);
      fetch_en = 1'b1;
      tick();
      chk("t6_valid0", {31'd0, o_valid}, 32'd1);
      chk("t6_addr0", o_addr, 32'h0000_0000);
      tick();
      chk("t6_addr1", o_addr, 32'h0000_0004);
      tick();
      chk("t6_credit_stop", {31'd0, o_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
